// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins. Aux results are queued and drain into idle slots.
// Writes are registered one cycle after the input. aux_ready drops while the FIFO is full; stall_req asserts when the queue head starves.
module wb_port_arbiter #(
  parameter int XLEN         = 64,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      pipe_wb,
  input  logic [XLEN-1:0] pipe_dm_data,
  input  logic [XLEN-1:0] pipe_alu,
  input  logic [4:0]      pipe_rd,
  input  logic            aux_valid,
  output logic            aux_ready,
  input  logic [4:0]      aux_rd,
  input  logic [XLEN-1:0] aux_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            stall_req,
  output logic            aux_pending
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]      r_mem_rd   [DEPTH];
  logic [XLEN-1:0] r_mem_data [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic            r_we;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_stall;

  logic            w_pipe_we;
  logic [XLEN-1:0] w_pipe_data;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [SW-1:0]   w_starve_nxt;

  // A write to x0 is architecturally a no-op, so it frees the port for the FIFO.
  assign w_pipe_we   = pipe_wb[1] && (pipe_rd != 5'd0);
  assign w_pipe_data = pipe_wb[0] ? pipe_dm_data : pipe_alu;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_push      = aux_valid && !w_full && (aux_rd != 5'd0);
  assign w_pop       = !w_pipe_we && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= aux_rd;
      r_mem_data[r_wptr] <= aux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Counts how long the current head has waited; restarts for each new head.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if (r_starve != STARVE_MAX) begin
      w_starve_nxt = r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == STARVE_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_pipe_we) begin
      r_we    <= 1'b1;
      r_waddr <= pipe_rd;
      r_wdata <= w_pipe_data;
    end else if (!w_empty) begin
      r_we    <= 1'b1;
      r_waddr <= r_mem_rd[r_rptr];
      r_wdata <= r_mem_data[r_rptr];
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign aux_ready   = !w_full;
  assign aux_pending = !w_empty;
  assign rf_we       = r_we;
  assign rf_waddr    = r_waddr;
  assign rf_wdata    = r_wdata;
  assign stall_req   = r_stall;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: per-cycle write expectations queued at drive time, compared at negedge.
module tb_wb_port_arbiter;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic            clk;
  logic            reset;
  logic [1:0]      pipe_wb;
  logic [XLEN-1:0] pipe_dm_data;
  logic [XLEN-1:0] pipe_alu;
  logic [4:0]      pipe_rd;
  logic            aux_valid;
  logic            aux_ready;
  logic [4:0]      aux_rd;
  logic [XLEN-1:0] aux_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            stall_req;
  logic            aux_pending;

  typedef struct {
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  exp_t exp_q[$];
  ent_t m_fifo[$];
  int   checks = 0;
  int   errors = 0;

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .pipe_wb(pipe_wb), .pipe_dm_data(pipe_dm_data),
    .pipe_alu(pipe_alu), .pipe_rd(pipe_rd), .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_rd(aux_rd), .aux_data(aux_data), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .stall_req(stall_req), .aux_pending(aux_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model one cycle from the current inputs, queue the expected write, then clock.
  task automatic step();
    exp_t e;
    ent_t n;
    bit   full;
    e.we = 1'b0; e.addr = '0; e.data = '0;
    if (reset) begin
      m_fifo.delete();
    end else begin
      full = (m_fifo.size() == DEPTH);
      if (pipe_wb[1] && pipe_rd != 5'd0) begin
        e.we = 1'b1; e.addr = pipe_rd; e.data = pipe_wb[0] ? pipe_dm_data : pipe_alu;
      end else if (m_fifo.size() != 0) begin
        n = m_fifo.pop_front();
        e.we = 1'b1; e.addr = n.rd; e.data = n.data;
      end
      if (aux_valid && !full && aux_rd != 5'd0) begin
        n.rd = aux_rd; n.data = aux_data;
        m_fifo.push_back(n);
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wb = 2'b00; pipe_rd = '0; pipe_dm_data = '0; pipe_alu = '0;
    aux_valid = 1'b0; aux_rd = '0; aux_data = '0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rf_we !== e.we || (e.we && (rf_waddr !== e.addr || rf_wdata !== e.data))) begin
          errors++;
          $display("FAIL sb_write t=%0t: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                   $time, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; aux_valid = 1'b1; aux_rd = 5'd9; aux_data = 64'h1111;
    step(); step();
    checks++;
    if (rf_we !== 1'b0 || stall_req !== 1'b0 || aux_ready !== 1'b1 || aux_pending !== 1'b0 ||
        rf_waddr !== 5'd0 || rf_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state: we=%0b stall=%0b rdy=%0b pend=%0b addr=%0d data=%h, want 0 0 1 0 0 0",
               rf_we, stall_req, aux_ready, aux_pending, rf_waddr, rf_wdata);
    end
    reset = 1'b0; aux_valid = 1'b0;
    step();
    checks++;
    if (aux_pending !== 1'b0) begin
      errors++; $display("FAIL reset_no_push: pend=%0b, want 0", aux_pending);
    end
  endtask

  task automatic test_priority();
    pipe_wb = 2'b11; pipe_rd = 5'd5; pipe_dm_data = 64'hAA; pipe_alu = 64'hBB;
    aux_valid = 1'b1; aux_rd = 5'd7; aux_data = 64'h55;
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hAA || aux_pending !== 1'b1) begin
      errors++;
      $display("FAIL prio_pipe: we=%0b addr=%0d data=%h pend=%0b, want 1 5 aa 1",
               rf_we, rf_waddr, rf_wdata, aux_pending);
    end
    idle_inputs();
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'h55 || aux_pending !== 1'b0) begin
      errors++;
      $display("FAIL prio_aux: we=%0b addr=%0d data=%h pend=%0b, want 1 7 55 0",
               rf_we, rf_waddr, rf_wdata, aux_pending);
    end
  endtask

  task automatic test_alu_x0();
    pipe_wb = 2'b10; pipe_rd = 5'd3; pipe_alu = 64'h1234; pipe_dm_data = 64'hDEAD;
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'h1234) begin
      errors++;
      $display("FAIL alu_sel: we=%0b addr=%0d data=%h, want 1 3 1234", rf_we, rf_waddr, rf_wdata);
    end
    pipe_rd = 5'd0;
    step();
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL x0_pipe: we=%0b, want 0", rf_we);
    end
    idle_inputs();
    aux_valid = 1'b1; aux_rd = 5'd0; aux_data = 64'h77;
    step();
    checks++;
    if (aux_pending !== 1'b0) begin
      errors++; $display("FAIL x0_aux: pend=%0b, want 0", aux_pending);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_full_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_wb = 2'b10; pipe_rd = 5'd1; pipe_alu = 64'(r * 16 + i);
        aux_valid = 1'b1; aux_rd = 5'(10 + i + r); aux_data = 64'(256 * r + i + 1);
        step();
      end
      checks++;
      if (aux_ready !== 1'b0 || aux_pending !== 1'b1) begin
        errors++; $display("FAIL full_r%0d: rdy=%0b pend=%0b, want 0 1", r, aux_ready, aux_pending);
      end
      aux_rd = 5'd31; aux_data = 64'hBAD;
      step();
      idle_inputs();
      step();
      checks++;
      if (aux_ready !== 1'b1) begin
        errors++; $display("FAIL ready_after_pop_r%0d: rdy=%0b, want 1", r, aux_ready);
      end
      for (int i = 1; i < DEPTH; i++) step();
      checks++;
      if (aux_pending !== 1'b0) begin
        errors++; $display("FAIL drained_r%0d: pend=%0b, want 0", r, aux_pending);
      end
    end
  endtask

  task automatic test_starvation();
    pipe_wb = 2'b11; pipe_rd = 5'd2; pipe_dm_data = 64'h10;
    aux_valid = 1'b1; aux_rd = 5'd9; aux_data = 64'h99;
    step();
    aux_valid = 1'b0;
    for (int k = 1; k <= LIMIT + 1; k++) begin
      pipe_dm_data = 64'(16 + k);
      step();
      checks++;
      if (stall_req !== (k >= LIMIT)) begin
        errors++; $display("FAIL starve_k%0d: stall=%0b, want %0b", k, stall_req, (k >= LIMIT));
      end
    end
    idle_inputs();
    step();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h99 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL starve_release: we=%0b addr=%0d data=%h stall=%0b, want 1 9 99 0",
               rf_we, rf_waddr, rf_wdata, stall_req);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      pipe_wb = 2'b10; pipe_rd = 5'd4; pipe_alu = 64'(i);
      aux_valid = 1'b1; aux_rd = 5'(20 + i); aux_data = 64'(100 + i);
      step();
    end
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (aux_pending !== 1'b0 || rf_we !== 1'b0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: pend=%0b we=%0b stall=%0b, want 0 0 0", aux_pending, rf_we, stall_req);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      pipe_wb      = ($urandom_range(0, 3) != 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      pipe_rd      = 5'($urandom_range(0, 7));
      pipe_dm_data = {$urandom, $urandom};
      pipe_alu     = {$urandom, $urandom};
      aux_valid    = 1'($urandom_range(0, 1));
      aux_rd       = 5'($urandom_range(0, 31));
      aux_data     = {$urandom, $urandom};
      checks++;
      if (aux_ready !== (m_fifo.size() != DEPTH) || aux_pending !== (m_fifo.size() != 0)) begin
        errors++;
        $display("FAIL rand_flags n=%0d: rdy=%0b pend=%0b, model size=%0d", n, aux_ready, aux_pending,
                 m_fifo.size());
      end
      step();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) step();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_priority();
    test_alu_x0();
    test_full_wrap();
    test_starvation();
    test_reset_mid();
    test_random();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
